// File: rtl/light_decoder_pkg.sv
// Shared colour table, event type and RGB decode for the light decoder slice.
// LIGHT_DECODER_RAW_EN adds the raw 24-bit value to each event.
package light_pkg;

  localparam int unsigned RGB_W    = 24;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [RGB_W-1:0] BLACK   = 24'h000000;
  localparam logic [RGB_W-1:0] BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] WHITE   = 24'hFFFFFF;

  typedef enum logic [COLOUR_W-1:0] {
    C_BLACK, C_BLUE, C_GREEN, C_CYAN, C_RED, C_MAGENTA, C_YELLOW, C_WHITE
  } colour_e;

  typedef struct packed {
`ifdef LIGHT_DECODER_RAW_EN
    logic [RGB_W-1:0]    raw;
`endif
    logic                known;
    logic [COLOUR_W-1:0] colour;
  } evt_t;

  // Exact-match lookup; anything off-table decodes as {known=0, colour=0}.
  function automatic logic [COLOUR_W:0] decode_rgb(input logic [RGB_W-1:0] rgb);
    case (rgb)
      BLACK:   return {1'b1, C_BLACK};
      BLUE:    return {1'b1, C_BLUE};
      GREEN:   return {1'b1, C_GREEN};
      CYAN:    return {1'b1, C_CYAN};
      RED:     return {1'b1, C_RED};
      MAGENTA: return {1'b1, C_MAGENTA};
      YELLOW:  return {1'b1, C_YELLOW};
      WHITE:   return {1'b1, C_WHITE};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/light_decoder_if.sv
// Event handshake bundle between the light decoder and its consumer.
// LIGHT_DECODER_RAW_EN adds evt_raw.
interface light_decoder_if;

  logic                               evt_valid;
  logic                               evt_ready;
  logic [light_pkg::COLOUR_W-1:0]     evt_colour;
  logic                               evt_known;
`ifdef LIGHT_DECODER_RAW_EN
  logic [light_pkg::RGB_W-1:0]        evt_raw;

  modport master (output evt_valid, evt_colour, evt_known, evt_raw, input evt_ready);
  modport slave  (input evt_valid, evt_colour, evt_known, evt_raw, output evt_ready);
`else
  modport master (output evt_valid, evt_colour, evt_known, input evt_ready);
  modport slave  (input evt_valid, evt_colour, evt_known, output evt_ready);
`endif

endinterface

// File: rtl/light_decoder_event_fifo.sv
// First-word fall-through event FIFO; head is readable the cycle after a push.
// A push while full is accepted only when a pop happens on the same edge.
module event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_decoder.sv
// Recovers colour codes from the RGB light bus, debounced by a stability window,
// and queues one event per committed change. LIGHT_DECODER_RAW_EN adds evt_raw.
module light_decoder
  import light_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RGB_W-1:0]     light,
  light_decoder_if.master      evt,
  output logic [CNT_W-1:0]     change_count,
  output logic                 overflow
);

  localparam int unsigned EVT_W = $bits(evt_t);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  logic [RGB_W-1:0]    light_q, light_d, committed_q, committed_d;
  logic [7:0]          stab_q, stab_d;
  logic                has_commit_q, has_commit_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                commit, pop, fifo_full, fifo_empty;
  logic [AW:0]         fifo_count;
  logic [COLOUR_W:0]   dec;
  evt_t                push_evt, head_evt;

  assign pop = !fifo_empty && evt.evt_ready;

  always_comb begin
    light_d      = light;
    stab_d       = stab_q;
    committed_d  = committed_q;
    has_commit_d = has_commit_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    // Commit on the edge that would bring the window count up to STABLE_CYCLES.
    commit = (light == light_q) && (stab_q == 8'(STABLE_CYCLES - 1)) &&
             (!has_commit_q || (light_q != committed_q));
    if (light != light_q) begin
      stab_d = 8'd1;
    end else if (stab_q != 8'(STABLE_CYCLES)) begin
      stab_d = stab_q + 8'd1;
    end
    if (commit) begin
      committed_d  = light_q;
      has_commit_d = 1'b1;
      count_d      = count_q + CNT_W'(1);
      if (fifo_full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    dec             = decode_rgb(light_q);
    push_evt        = '0;
    push_evt.known  = dec[COLOUR_W];
    push_evt.colour = dec[COLOUR_W-1:0];
`ifdef LIGHT_DECODER_RAW_EN
    push_evt.raw    = light_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_q      <= '0;
      stab_q       <= '0;
      committed_q  <= '0;
      has_commit_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      light_q      <= light_d;
      stab_q       <= stab_d;
      committed_q  <= committed_d;
      has_commit_q <= has_commit_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (commit),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt.evt_valid  = (fifo_count != '0);
  assign evt.evt_colour = fifo_empty ? '0 : head_evt.colour;
  assign evt.evt_known  = !fifo_empty && head_evt.known;
`ifdef LIGHT_DECODER_RAW_EN
  assign evt.evt_raw    = fifo_empty ? '0 : head_evt.raw;
`endif
  assign change_count   = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_light_decoder.sv
// Scoreboard bench for light_decoder: a run-length reference model queues expected
// events, a negedge monitor checks the head and status outputs every cycle.
module tb_light_decoder;
  import light_pkg::*;

  localparam int unsigned STABLE = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic [23:0]   light = '0;
  logic [CW-1:0] change_count;
  logic          overflow;

  light_decoder_if evt_if ();

  light_decoder #(
    .STABLE_CYCLES (STABLE),
    .FIFO_DEPTH    (DEPTH),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .light        (light),
    .evt          (evt_if),
    .change_count (change_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  colour;
    logic        known;
    logic [23:0] raw;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] palette [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                               24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

  // Reference state: length of the current run of identical samples, last committed
  // value, predicted FIFO occupancy and status outputs.
  logic [23:0]   run_val   = '0;
  int unsigned   run_len   = 0;
  logic [23:0]   committed = '0;
  bit            has_c     = 0;
  int unsigned   occ       = 0;
  logic [CW-1:0] m_count   = '0;
  bit            m_ovf     = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t lookup(input logic [23:0] v);
    exp_t e;
    e.colour = 3'd0;
    e.known  = 1'b0;
    e.raw    = v;
    for (int i = 0; i < 8; i++) begin
      if (palette[i] == v) begin
        e.colour = 3'(i);
        e.known  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    run_val   = '0;
    run_len   = 0;
    committed = '0;
    has_c     = 0;
    occ       = 0;
    m_count   = '0;
    m_ovf     = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit pop, pushed;
    pop    = (occ != 0) && evt_if.evt_ready;
    pushed = 0;
    if (light == run_val) begin
      if (run_len < STABLE) run_len++;
    end else begin
      run_val = light;
      run_len = 1;
    end
    if (run_len == STABLE && (!has_c || run_val != committed)) begin
      has_c     = 1;
      committed = run_val;
      m_count   = m_count + 1'b1;
      if (occ == DEPTH && !pop) begin
        m_ovf = 1;
      end else begin
        exp_q.push_back(lookup(run_val));
        pushed = 1;
      end
    end
    occ = occ - (pop ? 1 : 0) + (pushed ? 1 : 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else      model_edge();
  end

  // Monitor: compares the presented head and status against the model every cycle.
  initial forever begin
    @(negedge clk);
    check("evt_valid", evt_if.evt_valid, (occ != 0));
    check("change_count", change_count, m_count);
    check("overflow", overflow, m_ovf);
    if (evt_if.evt_valid) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        check("head_colour", evt_if.evt_colour, exp_q[0].colour);
        check("head_known", evt_if.evt_known, exp_q[0].known);
`ifdef LIGHT_DECODER_RAW_EN
        check("head_raw", evt_if.evt_raw, exp_q[0].raw);
`endif
        if (evt_if.evt_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("idle_colour", evt_if.evt_colour, 0);
      check("idle_known", evt_if.evt_known, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [23:0] v, input int n);
    light = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic drain();
    int k;
    evt_if.evt_ready = 1'b1;
    k = 0;
    while (evt_if.evt_valid && k < 32) begin
      step();
      k++;
    end
    check("drain_done", evt_if.evt_valid, 0);
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] v;
    evt_if.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_valid", evt_if.evt_valid, 0);
    check("reset_count", change_count, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b1;

    // Green held: event appears right after the 4th sampling edge.
    light = 24'h00FF00;
    repeat (3) step();
    check("green_pre_commit", evt_if.evt_valid, 0);
    step();
    check("green_valid", evt_if.evt_valid, 1);
    check("green_colour", evt_if.evt_colour, 2);
    check("green_known", evt_if.evt_known, 1);
    repeat (6) step();
    check("green_count", change_count, 1);

    // Short glitch and return to the committed value.
    hold(24'hFF0000, 6);
    hold(24'h0000FF, 2);
    hold(24'hFF0000, 6);
    check("glitch_count", change_count, 2);
    drain();

    // Five commits into a four-deep FIFO with no consumer.
    do_reset();
    for (int c = 1; c <= 5; c++) hold(palette[c], 6);
    check("ovf_set", overflow, 1);
    check("ovf_count", change_count, 5);
    drain();

    // Two off-table values.
    hold(24'h123456, 6);
    hold(24'h654321, 6);
    check("unknown_count", change_count, 7);

    // Asynchronous reset mid-window with events queued.
    light = 24'h00FF00;
    step();
    step();
    rst = 1'b0;
    #1;
    check("async_valid", evt_if.evt_valid, 0);
    check("async_count", change_count, 0);
    check("async_overflow", overflow, 0);
    step();
    rst = 1'b1;
    hold(24'h000000, 6);
    check("black_count", change_count, 1);
    check("black_valid", evt_if.evt_valid, 1);
    check("black_colour", evt_if.evt_colour, 0);
    check("black_known", evt_if.evt_known, 1);
    drain();

    // Full FIFO with a commit and a pop on the same edge.
    for (int c = 1; c <= 4; c++) hold(palette[c], 6);
    light = palette[5];
    repeat (3) step();
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    step();
    check("simul_no_ovf", overflow, 0);
    check("simul_count", change_count, 6);
    drain();

    // Randomised runs of palette and off-table values with a random consumer.
    repeat (80) begin
      if ($urandom_range(0, 9) < 8) v = palette[$urandom_range(0, 7)];
      else                          v = 24'($urandom());
      light = v;
      repeat ($urandom_range(1, 7)) begin
        evt_if.evt_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
